prn_alloc: RTL

PRN_ALLOC -- requirements
Module: prn_alloc

---
 rtl/prn_alloc.sv | 82 ++++++++
 1 files changed

// File: rtl/prn_alloc.sv
// prn_alloc: two-slot physical register allocator with per-thread in-flight tracking and mispredict recovery; ports: clock/reset, alloc_req/alloc_thread -> alloc_gnt/free_PRN/alloc_stall, retire_* frees old PRNs, mispredict_thread_0/1 reclaim in-flight PRNs, free_count
module prn_alloc #(
  parameter int PR_ENTRIES    = 96,
  parameter int PR_BITS       = 7,
  parameter int ARCH_RESERVED = 64
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [1:0]              alloc_req,
  input  logic                    alloc_thread,
  output logic [1:0]              alloc_gnt,
  output logic [1:0][PR_BITS-1:0] free_PRN,
  output logic                    alloc_stall,
  input  logic [1:0]              retire_valid,
  input  logic [1:0]              retire_thread,
  input  logic [1:0][PR_BITS-1:0] retire_new_PRN,
  input  logic [1:0][PR_BITS-1:0] retire_old_PRN,
  input  logic                    mispredict_thread_0,
  input  logic                    mispredict_thread_1,
  output logic [PR_BITS:0]        free_count
);
  localparam logic [PR_ENTRIES-1:0] RST_FREE = {PR_ENTRIES{1'b1}} << ARCH_RESERVED;
  logic [PR_ENTRIES-1:0] free_q, free_d, inf0_q, inf0_d, inf1_q, inf1_d;
  logic [PR_BITS-1:0] lo0, lo1;
  logic [PR_BITS:0] nreq;
  logic mp;
  always_comb begin
    lo0 = '0;
    lo1 = '0;
    free_count = '0;
    for (int i = PR_ENTRIES - 1; i >= 0; i--) begin
      if (free_q[i]) begin
        lo1 = lo0;
        lo0 = PR_BITS'(i);
      end
      free_count = free_count + (PR_BITS+1)'(free_q[i]);
    end
  end
  assign mp          = alloc_thread ? mispredict_thread_1 : mispredict_thread_0;
  assign nreq        = (PR_BITS+1)'(alloc_req[0]) + (PR_BITS+1)'(alloc_req[1]);
  assign alloc_stall = !reset && !mp && (nreq > free_count);
  assign alloc_gnt   = (reset || mp || alloc_stall) ? 2'b00 : alloc_req;
  assign free_PRN    = {alloc_req[0] ? lo1 : lo0, lo0};
  always_comb begin
    free_d = free_q;
    inf0_d = inf0_q;
    inf1_d = inf1_q;
    for (int s = 0; s < 2; s++)
      if (alloc_gnt[s]) begin
        free_d[free_PRN[s]] = 1'b0;
        inf0_d[free_PRN[s]] = inf0_d[free_PRN[s]] | !alloc_thread;
        inf1_d[free_PRN[s]] = inf1_d[free_PRN[s]] | alloc_thread;
      end
    for (int s = 0; s < 2; s++)
      if (retire_valid[s]) begin
        inf0_d[retire_new_PRN[s]] = inf0_d[retire_new_PRN[s]] & retire_thread[s];
        inf1_d[retire_new_PRN[s]] = inf1_d[retire_new_PRN[s]] & !retire_thread[s];
        free_d[retire_old_PRN[s]] = 1'b1;
        inf0_d[retire_old_PRN[s]] = 1'b0;
        inf1_d[retire_old_PRN[s]] = 1'b0;
      end
    free_d = free_d | (mispredict_thread_0 ? inf0_d : '0) | (mispredict_thread_1 ? inf1_d : '0);
    inf0_d = mispredict_thread_0 ? '0 : inf0_d;
    inf1_d = mispredict_thread_1 ? '0 : inf1_d;
  end
  always_ff @(posedge clock)
    if (reset) begin
      free_q <= RST_FREE;
      inf0_q <= '0;
      inf1_q <= '0;
    end else begin
      free_q <= free_d;
      inf0_q <= inf0_d;
      inf1_q <= inf1_d;
    end
  always_ff @(posedge clock)
    if (!reset) begin
      for (int s = 0; s < 2; s++)
        assert (!(retire_valid[s] && free_q[retire_old_PRN[s]]));
      assert (!(&retire_valid && retire_old_PRN[0] == retire_old_PRN[1]));
    end
endmodule
